// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default width.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_sub_half_sub.sv
// Half subtractor cell, x - y: difference bit and borrow-out.
module half_sub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: LSB-first, one bit per clock, valid/ready on both sides.
//
//   state | meaning
//   IDLE  | waiting for operands, in_ready=1
//   SHIFT | one difference bit produced per edge, WIDTH edges total
//   DONE  | result presented with out_valid=1 until out_ready
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t            state;
    state_t            state_next;
    logic [WIDTH-1:0]  a_shift;
    logic [WIDTH-1:0]  b_shift;
    logic [WIDTH-1:0]  result;
    logic              borrow_flop;
    logic [CNT_W-1:0]  bit_cnt;

    logic d0;
    logic bo0;
    logic bit_diff;
    logic bo1;
    logic bout;

    // Full subtractor: (a0 - b0) first, then subtract the incoming borrow.
    half_sub u_hs_ab (
        .x  (a_shift[0]),
        .y  (b_shift[0]),
        .d  (d0),
        .bo (bo0)
    );

    half_sub u_hs_bin (
        .x  (d0),
        .y  (borrow_flop),
        .d  (bit_diff),
        .bo (bo1)
    );

    assign bout = bo0 | bo1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Result register is left untouched on accept so the previous answer stays visible in IDLE.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_shift     <= '0;
            b_shift     <= '0;
            result      <= '0;
            borrow_flop <= 1'b0;
            bit_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_shift     <= a;
                        b_shift     <= b;
                        borrow_flop <= 1'b0;
                        bit_cnt     <= '0;
                    end
                end
                SHIFT: begin
                    result      <= {bit_diff, result[WIDTH-1:1]};
                    a_shift     <= a_shift >> 1;
                    b_shift     <= b_shift >> 1;
                    borrow_flop <= bout;
                    bit_cnt     <= bit_cnt + CNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    assign diff   = result;
    assign borrow = borrow_flop;

endmodule

// File: tb/tb_serial_sub.sv
// Randomized self-checking bench for serial_sub against an arithmetic reference (a-b mod 256, a<b).
module tb_serial_sub;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] diff;
    logic       borrow;

    int tests;
    int errors;

    serial_sub #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at a negedge back in IDLE.
    task automatic run_op(input logic [7:0] op_a, input logic [7:0] op_b,
                          input int stall, input bit noisy);
        logic [7:0] exp_d;
        logic       exp_b;
        int         n;
        exp_d = 8'((int'(op_a) - int'(op_b) + 256) % 256);
        exp_b = (op_a < op_b);
        chk("idle_in_ready", 32'(in_ready), 32'd1);
        in_valid  = 1'b1;
        a         = op_a;
        b         = op_b;
        out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = noisy;
        a = 8'($urandom);
        b = 8'($urandom);
        chk("busy_in_ready", 32'(in_ready), 32'd0);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (noisy) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
        end
        chk("latency", 32'(n), 32'd8);
        chk("diff", 32'(diff), 32'(exp_d));
        chk("borrow", 32'(borrow), 32'(exp_b));
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (noisy) begin
                a = 8'($urandom);
                b = 8'($urandom);
            end
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_diff", 32'(diff), 32'(exp_d));
            chk("stall_borrow", 32'(borrow), 32'(exp_b));
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_valid", 32'(out_valid), 32'd0);
        chk("post_in_ready", 32'(in_ready), 32'd1);
        chk("hold_diff", 32'(diff), 32'(exp_d));
        chk("hold_borrow", 32'(borrow), 32'(exp_b));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        tests     = 0;
        errors    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_diff", 32'(diff), 32'd0);
        chk("rst_borrow", 32'(borrow), 32'd0);
        rst = 1'b0;

        run_op(8'h05, 8'h03, 0, 1'b0);
        run_op(8'h03, 8'h05, 0, 1'b0);
        run_op(8'h00, 8'h01, 0, 1'b0);
        run_op(8'hFF, 8'hFF, 0, 1'b0);
        run_op(8'h80, 8'h00, 0, 1'b0);
        run_op(8'h5A, 8'hA5, 20, 1'b1);

        // Abort mid-operation: reset sampled on the 4th SHIFT edge.
        in_valid = 1'b1;
        a = 8'h77;
        b = 8'h12;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b0;
        chk("abort_in_ready", 32'(in_ready), 32'd1);
        chk("abort_out_valid", 32'(out_valid), 32'd0);
        chk("abort_diff", 32'(diff), 32'd0);
        chk("abort_borrow", 32'(borrow), 32'd0);
        run_op(8'h10, 8'h01, 0, 1'b0);

        // Back-to-back with both sides always ready: one result every 10 cycles.
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a = 8'h9C;
        b = 8'h3F;
        t = 0;
        while (!out_valid && t < 40) begin
            @(negedge clk);
            t++;
        end
        chk("b2b_first", 32'(out_valid), 32'd1);
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!out_valid && t < 40);
        chk("b2b_period", 32'(t), 32'd10);
        chk("b2b_diff", 32'(diff), 32'h5D);
        in_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("b2b_idle", 32'(in_ready), 32'd1);

        for (int i = 0; i < 1000; i++) begin
            run_op(8'($urandom), 8'($urandom), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", tests, errors);
        $finish;
    end

endmodule

// File: doc/serial_sub.md
SERIAL_SUB -- requirements
Module: serial_sub

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  rising-edge clock, single clock domain.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand pair a/b present.
REQ-005 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-006 a  input  WIDTH  minuend, unsigned.
REQ-007 b  input  WIDTH  subtrahend, unsigned.
REQ-008 out_valid  output  1  diff/borrow hold a valid result.
REQ-009 out_ready  input  1  consumer accepts the result.
REQ-010 diff  output  WIDTH  (a - b) mod 2^WIDTH.
REQ-011 borrow  output  1  final borrow-out; 1 iff a < b (unsigned).

Function
REQ-012 The FSM SHALL have three states: IDLE, SHIFT and DONE.
REQ-013 IDLE: in_ready=1; when in_valid=1, the edge latches a and b into shift registers, clears the borrow flop, loads the bit counter with 0, and moves to SHIFT.
REQ-014 SHIFT: each edge SHALL process one bit, LSB first.
REQ-015 Per-bit operation: d = a0 ^ b0 ^ bin and bout = (~a0 & b0) | (~(a0 ^ b0) & bin), built from two half-subtractor cells.
REQ-016 In SHIFT, d SHALL shift into the MSB of the result register (right shift), a/b SHALL shift right, and bout SHALL register as the next bin.
REQ-017 After exactly WIDTH SHIFT edges, the state SHALL become DONE; out_valid rises WIDTH edges after the accept edge.
REQ-018 DONE: out_valid=1, and diff/borrow SHALL be stable until the handshake completes.
REQ-019 On the edge where out_valid=1 and out_ready=1, the FSM SHALL return to IDLE; out_valid SHALL then drop.
REQ-020 out_ready held low SHALL stall the block in DONE indefinitely, with no loss or change of result.
REQ-021 in_valid during SHIFT or DONE SHALL be ignored (in_ready=0); there is no operand buffering.
REQ-022 Back-to-back throughput: one result per WIDTH+2 cycles when out_ready is held at 1.
REQ-023 diff and borrow SHALL keep their last result after returning to IDLE until the next SHIFT begins overwriting.
REQ-024 The counter SHALL be $clog2(WIDTH+1) bits wide and never wrap during an operation.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, out_valid=0, diff=0, borrow=0, counter=0 and shift registers=0, with in_ready=1 on the following cycle.
REQ-026 Reset asserted mid-SHIFT or in DONE SHALL abort the operation, with no result presented.
REQ-027 rst SHALL take priority over every handshake in the same cycle.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2) and the default WIDTH constant.
REQ-029 One combinational sub-module, half_sub (inputs x, y; outputs d=x^y, bo=~x&y), SHALL be instantiated twice to form the per-bit full subtractor; bout is the OR of the two bo outputs.
REQ-030 All other logic (FSM, counter, shift registers, borrow flop) SHALL reside in serial_sub.

Verification
REQ-031 WIDTH=8, a=0x05, b=0x03, out_ready=1 -> out_valid 8 edges after accept, diff=0x02, borrow=0.
REQ-032 a=0x03, b=0x05 -> diff=0xFE, borrow=1; then a=0x00, b=0x01 -> diff=0xFF, borrow=1 (full borrow ripple).
REQ-033 a=0xFF, b=0xFF and a=0x80, b=0x00 -> diff=0x00/borrow=0 and diff=0x80/borrow=0.
REQ-034 out_ready held 0 for 20 cycles after out_valid, with in_valid=1 and new operands applied throughout -> diff/borrow unchanged, in_ready=0, first result delivered intact.
REQ-035 rst pulsed on the 4th SHIFT edge -> next cycle IDLE, out_valid=0, diff=0; a following a=0x10, b=0x01 yields diff=0x0F, borrow=0.
REQ-036 Random self-check: 1000 random a/b pairs against a reference (a-b) mod 256 and (a<b), with random out_ready stalls.
